imm_narrow16_to_4: RTL and testbench
====================================

// Module: imm_narrow16_to_4
// PURPOSE
//  Inverse of the 4->16 immediate sign extender. Takes a 16-bit operand and emits it as 4-bit immediate nibbles.
//  Short form: one nibble when the value survives 16->4 sign extension unchanged.
//  Long form: four nibbles, MSB first, for the assembler/loader path.
//  Sits between the constant/operand source and the 4-bit immediate field of the instruction stream.
//  Valid/ready on both sides.
// PARAMETERS
//  IN_W   16  input operand width; fixed at 16 for KURM.
//  OUT_W  4   nibble width; IN_W must equal 4*OUT_W.
//  CNT_W  8   width of the saturating statistics counters.
// PORTS
//  clk        in   1      single clock, rising edge.
//  rst_n      in   1      asynchronous, active-low reset.
//  in_valid   in   1      in_data is offered.
//  in_ready   out  1      block can accept an operand.
//  in_data    in   16     operand to narrow.
//  out_valid  out  1      out_nibble is valid.
//  out_ready  in   1      consumer takes the nibble.
//  out_nibble out  4      current nibble.
//  out_first  out  1      first nibble of an operand.
//  out_last   out  1      last nibble of an operand.
//  out_fits   out  1      1 = short form (single nibble); constant across one operand.
//  short_cnt  out  CNT_W  count of short-form operands accepted; saturates at 255.
//  long_cnt   out  CNT_W  count of long-form operands accepted; saturates at 255.
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE.
//    - in_ready=1, out_valid=0.
//    - out_nibble, out_first, out_last and out_fits = 0.
//    - both counters = 0.
//  - FSM states: IDLE, EMIT.
//    - in_ready = (state==IDLE), registered.
//    - Accept occurs when in_valid && in_ready.
//  - On accept:
//    - fits = (in_data[15:3] all 0) || (in_data[15:3] all 1).
//    - Capture in_data into a shift register.
//    - Load nibble count: 1 if fits, else 4.
//    - Go to EMIT.
//  - Latency: out_valid=1 on the cycle after accept, carrying the first nibble.
//    - fits: nibble = in_data[3:0], first=last=1.
//    - not fits: nibbles in order [15:12], [11:8], [7:4], [3:0]; first on #1, last on #4.
//  - Output handshake:
//    - out_nibble, first, last and fits are held stable while out_valid && !out_ready.
//    - out_valid never drops without a handshake.
//    - Each out_valid && out_ready advances to the next nibble on the next cycle, with no bubble.
//  - After the handshake on the last nibble: out_valid=0, state=IDLE, in_ready=1 the next cycle.
//    - No accept in the same cycle as the last handshake.
//    - Peak throughput: short form = 1 operand per 2 cycles; long form = 1 per 5 cycles.
//  - Counters:
//    - Increment on accept: short_cnt when fits, long_cnt otherwise.
//    - Hold at 255; no wrap.
//  - Round-trip invariants:
//    - Short form: sign-extending the nibble gives in_data.
//    - Long form: concatenating the 4 nibbles gives in_data.
//  - Boundaries:
//    - 0xFFF8 (-8) and 0x0007 (+7) are short form.
//    - 0xFFF7 and 0x0008 are long form.
//    - 0x0000 and 0xFFFF are short form.
//  - in_valid is ignored while in EMIT; the source must hold its data until in_ready.
//  - Reset asserted mid-operation drops the partial sequence immediately. No nibble is emitted after rst_n rises until a new accept.
// STRUCTURE
//  - Shared package kurm_imm_pkg holds:
//    - IMM_IN_W=16, IMM_OUT_W=4.
//    - FSM state typedef/localparams (IDLE, EMIT).
//    - NIB_LONG=4.
//  - One sub-module, imm_fit_check: combinational; in[15:0] -> fits. Reusable by the decoder and assembler checks.
//  - Top level contains the FSM, the 16-bit left-shift register, a 2-bit remaining-nibble counter and the saturating counters.
// TESTING
//  1. in_data=0xFFFD, out_ready=1:
//     - one nibble 4'b1101, first=last=1, fits=1, on the cycle after accept.
//     - short_cnt=1.
//  2. in_data=0x0008:
//     - nibbles 0,0,0,8 on 4 consecutive cycles, fits=0.
//     - first only on the first nibble, last only on the fourth.
//     - long_cnt=1.
//  3. in_data=0x1234, out_ready low 3 cycles on nibble #2:
//     - out_nibble holds 4'h2 with out_valid=1 throughout.
//     - Then 3, 4 follow.
//     - in_ready stays 0 until after the last handshake.
//  4. Sequence 0x0007, 0xFFF8, 0xFFF7:
//     - first two are short form (7, 8); third is long form F,F,F,7.
//     - short_cnt=2, long_cnt=1.
//  5. rst_n pulsed low mid-way through 0xABCD (after nibble A):
//     - out_valid=0 and in_ready=1 immediately.
//     - No B/C/D afterwards; counters = 0.
//  6. 300 short-form accepts:
//     - short_cnt stops at 255 and does not wrap.
//     - long_cnt stays 0.

Source files
------------

// File: rtl/kurm_imm_pkg.sv
// Shared constants and types for the KURM immediate narrowing/extension path.
// Imported by the fit checker and the 16->4 narrower.
package kurm_imm_pkg;

    localparam int unsigned IMM_IN_W  = 16;
    localparam int unsigned IMM_OUT_W = 4;
    localparam int unsigned IMM_CNT_W = 8;
    localparam int unsigned NIB_LONG  = 4;

    // Wide enough to count down the remaining nibbles of a long-form operand.
    localparam int unsigned IMM_REM_W = 2;

    typedef enum logic {
        StIdle = 1'b0,
        StEmit = 1'b1
    } imm_state_e;

endpackage

// File: rtl/imm_fit_check.sv
// Combinational short-form test: a value fits the narrow immediate when it survives
// sign extension from OUT_W bits unchanged.
module imm_fit_check
    import kurm_imm_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_IN_W,
    parameter int unsigned OUT_W = IMM_OUT_W
) (
    input  logic [IN_W-1:0] data_i,
    output logic            fits_o
);

    // Everything from the narrow sign bit upward must be a copy of that sign bit.
    logic [IN_W-OUT_W:0] upper;
    logic                unused_low;

    assign upper      = data_i[IN_W-1:OUT_W-1];
    assign unused_low = ^data_i[OUT_W-2:0];
    assign fits_o     = (upper == '0) || (upper == '1);

endmodule

// File: rtl/imm_narrow16_to_4.sv
// Narrows a 16-bit operand into a stream of 4-bit immediate nibbles: one nibble when the
// value sign-extends back unchanged, otherwise four nibbles MSB first.
module imm_narrow16_to_4
    import kurm_imm_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_IN_W,
    parameter int unsigned OUT_W = IMM_OUT_W,
    parameter int unsigned CNT_W = IMM_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_nibble,
    output logic             out_first,
    output logic             out_last,
    output logic             out_fits,
    output logic [CNT_W-1:0] short_cnt,
    output logic [CNT_W-1:0] long_cnt
);

    imm_state_e           state_q, state_d;
    logic [IN_W-1:0]      shift_q, shift_d;
    logic [IMM_REM_W-1:0] rem_q, rem_d;
    logic                 first_q, first_d;
    logic                 fits_q, fits_d;
    logic [CNT_W-1:0]     short_cnt_q, short_cnt_d;
    logic [CNT_W-1:0]     long_cnt_q, long_cnt_d;

    logic in_fits;
    logic accept;
    logic out_hs;
    logic last_nib;

    imm_fit_check #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_fit_check (
        .data_i (in_data),
        .fits_o (in_fits)
    );

    assign accept   = in_valid && (state_q == StIdle);
    assign out_hs   = out_ready && (state_q == StEmit);
    assign last_nib = (rem_q == '0);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        rem_d       = rem_q;
        first_d     = first_q;
        fits_d      = fits_q;
        short_cnt_d = short_cnt_q;
        long_cnt_d  = long_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StEmit;
                    first_d = 1'b1;
                    fits_d  = in_fits;
                    if (in_fits) begin
                        // Park the single nibble where the long form would put its first one.
                        shift_d = {in_data[OUT_W-1:0], {(IN_W-OUT_W){1'b0}}};
                        rem_d   = '0;
                        if (short_cnt_q != '1) begin
                            short_cnt_d = short_cnt_q + 1'b1;
                        end
                    end else begin
                        shift_d = in_data;
                        rem_d   = IMM_REM_W'(NIB_LONG - 1);
                        if (long_cnt_q != '1) begin
                            long_cnt_d = long_cnt_q + 1'b1;
                        end
                    end
                end
            end
            StEmit: begin
                if (out_hs) begin
                    first_d = 1'b0;
                    if (last_nib) begin
                        state_d = StIdle;
                    end else begin
                        shift_d = {shift_q[IN_W-OUT_W-1:0], {OUT_W{1'b0}}};
                        rem_d   = rem_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            rem_q       <= '0;
            first_q     <= 1'b0;
            fits_q      <= 1'b0;
            short_cnt_q <= '0;
            long_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            fits_q      <= fits_d;
            short_cnt_q <= short_cnt_d;
            long_cnt_q  <= long_cnt_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StEmit);
    assign out_nibble = shift_q[IN_W-1 -: OUT_W];
    assign out_first  = out_valid && first_q;
    assign out_last   = out_valid && last_nib;
    assign out_fits   = fits_q;
    assign short_cnt  = short_cnt_q;
    assign long_cnt   = long_cnt_q;

endmodule

// File: tb/tb_imm_narrow16_to_4.sv
// Bench for imm_narrow16_to_4: directed cases with literal expectations plus a randomized
// run checked every cycle against a queue-based model of the nibble stream.
module tb_imm_narrow16_to_4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_nibble;
    logic        out_first;
    logic        out_last;
    logic        out_fits;
    logic [7:0]  short_cnt;
    logic [7:0]  long_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    imm_narrow16_to_4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nibble (out_nibble),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_fits   (out_fits),
        .short_cnt  (short_cnt),
        .long_cnt   (long_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0] nib;
        logic       first;
        logic       last;
        logic       fits;
    } beat_t;

    beat_t       mq[$];
    int unsigned m_short = 0;
    int unsigned m_long = 0;
    logic [3:0]  dut_log[$];

    function automatic bit model_fits(input logic [15:0] d);
        int v;
        v = int'($signed(d));
        return (v >= -8) && (v <= 7);
    endfunction

    task automatic model_accept(input logic [15:0] d);
        beat_t       b;
        logic [15:0] t;
        if (model_fits(d)) begin
            b.nib = d[3:0]; b.first = 1'b1; b.last = 1'b1; b.fits = 1'b1;
            mq.push_back(b);
            if (m_short < 255) m_short++;
        end else begin
            for (int k = 0; k < 4; k++) begin
                t = d >> (12 - 4 * k);
                b.nib = t[3:0]; b.first = (k == 0); b.last = (k == 3); b.fits = 1'b0;
                mq.push_back(b);
            end
            if (m_long < 255) m_long++;
        end
    endtask

    initial begin
        bit acc;
        bit pop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_short = 0;
                m_long = 0;
            end else begin
                acc = in_valid && (mq.size() == 0);
                pop = out_ready && (mq.size() != 0);
                if (pop) void'(mq.pop_front());
                if (acc) model_accept(in_data);
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("out_valid", out_valid, mq.size() != 0);
                check("in_ready", in_ready, mq.size() == 0);
                if (mq.size() != 0) begin
                    check("out_nibble", out_nibble, mq[0].nib);
                    check("out_first", out_first, mq[0].first);
                    check("out_last", out_last, mq[0].last);
                    check("out_fits", out_fits, mq[0].fits);
                end
                check("short_cnt", short_cnt, m_short);
                check("long_cnt", long_cnt, m_long);
                if (out_valid && out_ready) dut_log.push_back(out_nibble);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst out_nibble", out_nibble, 0);
        check("rst flags", {out_first, out_last, out_fits}, 0);
        check("rst counters", {short_cnt, long_cnt}, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        dut_log.delete();
    endtask

    // Returns one time unit after the accepting edge.
    task automatic send(input logic [15:0] d);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) timeout_fail("send");
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (mq.size() == 0) done = 1'b1;
        end
        if (!done) timeout_fail("drain");
        @(posedge clk); #1;
    endtask

    task automatic check_log(input string name, input logic [15:0] seq, input int n);
        logic [3:0] e;
        check({name, " count"}, dut_log.size(), n);
        for (int i = 0; i < n && i < dut_log.size(); i++) begin
            e = seq[15 - 4 * i -: 4];
            check({name, " nibble"}, dut_log[i], e);
        end
    endtask

    function automatic logic [15:0] gen_data();
        logic [15:0] r;
        logic [15:0] bnd[6];
        bnd[0] = 16'h0000; bnd[1] = 16'hFFFF; bnd[2] = 16'h0007;
        bnd[3] = 16'hFFF8; bnd[4] = 16'hFFF7; bnd[5] = 16'h0008;
        r = 16'($urandom);
        case ($urandom_range(0, 3))
            0: return {{12{r[3]}}, r[3:0]};
            1: return bnd[$urandom_range(0, 5)];
            default: return r;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit          acc;
        logic [15:0] r;

        do_reset();

        // 1: short form 0xFFFD
        out_ready = 1'b1;
        send(16'hFFFD);
        check("t1 valid", out_valid, 1);
        check("t1 nibble", out_nibble, 4'hD);
        check("t1 first/last/fits", {out_first, out_last, out_fits}, 3'b111);
        drain();
        check_log("t1", 16'hD000, 1);
        check("t1 short_cnt", short_cnt, 1);

        // 2: long form 0x0008
        do_reset();
        out_ready = 1'b1;
        send(16'h0008);
        check("t2 fits", out_fits, 0);
        drain();
        check_log("t2", 16'h0008, 4);
        check("t2 long_cnt", long_cnt, 1);

        // 3: stall on nibble #2 of 0x1234
        do_reset();
        out_ready = 1'b1;
        send(16'h1234);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3 hold nibble", out_nibble, 4'h2);
            check("t3 hold valid", out_valid, 1);
            check("t3 in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        check_log("t3", 16'h1234, 4);

        // 4: boundaries 0x0007, 0xFFF8, 0xFFF7
        do_reset();
        out_ready = 1'b1;
        send(16'h0007);
        send(16'hFFF8);
        send(16'hFFF7);
        drain();
        check("t4 count", dut_log.size(), 6);
        if (dut_log.size() == 6) begin
            check("t4 n0", dut_log[0], 4'h7);
            check("t4 n1", dut_log[1], 4'h8);
            check("t4 n2", dut_log[2], 4'hF);
            check("t4 n5", dut_log[5], 4'h7);
        end
        check("t4 short_cnt", short_cnt, 2);
        check("t4 long_cnt", long_cnt, 1);

        // 5: reset after nibble A of 0xABCD
        do_reset();
        out_ready = 1'b1;
        send(16'hABCD);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5 out_valid", out_valid, 0);
        check("t5 in_ready", in_ready, 1);
        check("t5 counters", {short_cnt, long_cnt}, 0);
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_log("t5", 16'hA000, 1);

        // 6: counter saturation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = 16'($urandom);
            send({{12{r[3]}}, r[3:0]});
        end
        drain();
        check("t6 short_cnt", short_cnt, 255);
        check("t6 long_cnt", long_cnt, 0);

        // Randomized traffic with backpressure and one mid-run reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = in_valid && (mq.size() == 0);
            @(posedge clk); #1;
            if (c == 1500) begin
                rst_n = 1'b0;
                in_valid = 1'b0;
                #3;
                rst_n = 1'b1;
            end else if (acc || !in_valid) begin
                if ($urandom_range(0, 2) != 0) begin
                    in_valid = 1'b1;
                    in_data = gen_data();
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
